// File: rtl/receptor_trena_7o1.sv
// Far-end 7O1 serial receiver for the trena measurement stream: deserializes
// characters and parses "ddd#" frames into BCD hundreds/tens/units.
module receptor_trena_7o1 #(
   parameter int CLKS_PER_BIT = 434,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       entrada_serial,
   output logic [3:0] centena,
   output logic [3:0] dezena,
   output logic [3:0] unidade,
   output logic       medida_pronto,
   output logic       erro_paridade,
   output logic       erro_formato,
   output logic [3:0] db_estado
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      START    = 4'd1,
      DATA     = 4'd2,
      PARIDADE = 4'd3,
      STOP     = 4'd4,
      PROCESSA = 4'd5
   } estado_t;

   estado_t       estado;
   logic          sync1, rx;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [6:0]    dado;
   logic          bit_par, bit_stop;
   logic [1:0]    indice;
   logic [3:0]    stg_c, stg_d, stg_u;
   logic          par_ok, eh_digito;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   assign par_ok    = ^{dado, bit_par};
   assign eh_digito = (dado >= 7'h30) && (dado <= 7'h39);
   assign db_estado = estado;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1         <= 1'b1;
         rx            <= 1'b1;
         estado        <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         dado          <= '0;
         bit_par       <= 1'b0;
         bit_stop      <= 1'b0;
         indice        <= '0;
         stg_c         <= '0;
         stg_d         <= '0;
         stg_u         <= '0;
         centena       <= '0;
         dezena        <= '0;
         unidade       <= '0;
         medida_pronto <= 1'b0;
         erro_paridade <= 1'b0;
         erro_formato  <= 1'b0;
      end else begin
         sync1         <= entrada_serial;
         rx            <= sync1;
         medida_pronto <= 1'b0;
         erro_paridade <= 1'b0;
         erro_formato  <= 1'b0;
         if (cnt != '0) cnt <= cnt - 1'b1;

         case (estado)
            IDLE: begin
               if (!rx) begin
                  cnt    <= CW'(HALF_BIT - 1);
                  estado <= START;
               end
            end
            START: begin
               if (cnt == '0) begin
                  if (rx) begin
                     estado <= IDLE;
                  end else begin
                     cnt     <= CW'(CLKS_PER_BIT - 1);
                     bit_idx <= '0;
                     estado  <= DATA;
                  end
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  dado <= {rx, dado[6:1]};
                  cnt  <= CW'(CLKS_PER_BIT - 1);
                  if (bit_idx == 3'd6) estado <= PARIDADE;
                  else bit_idx <= bit_idx + 1'b1;
               end
            end
            PARIDADE: begin
               if (cnt == '0) begin
                  bit_par <= rx;
                  cnt     <= CW'(CLKS_PER_BIT - 1);
                  estado  <= STOP;
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  bit_stop <= rx;
                  estado   <= PROCESSA;
               end
            end
            PROCESSA: begin
               estado <= IDLE;
               if (!par_ok || !bit_stop) begin
                  erro_paridade <= 1'b1;
                  indice        <= '0;
               end else if (indice != 2'd3) begin
                  if (eh_digito) begin
                     case (indice)
                        2'd0:    stg_c <= dado[3:0];
                        2'd1:    stg_d <= dado[3:0];
                        default: stg_u <= dado[3:0];
                     endcase
                     indice <= indice + 1'b1;
                  end else begin
                     erro_formato <= 1'b1;
                     indice       <= '0;
                  end
               end else begin
                  if (dado == 7'h23) begin
                     centena       <= stg_c;
                     dezena        <= stg_d;
                     unidade       <= stg_u;
                     medida_pronto <= 1'b1;
                  end else begin
                     erro_formato <= 1'b1;
                  end
                  indice <= '0;
               end
            end
            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_receptor_trena_7o1.sv
// Scoreboard bench for receptor_trena_7o1: an ideal 7O1 transmitter drives the
// line, a frame-level model predicts events, and a monitor checks each pulse.
module tb_receptor_trena_7o1;

   localparam int CPB = 8;
   localparam int EV_PRONTO = 0, EV_PAR = 1, EV_FMT = 2;

   typedef struct {
      int         kind;
      logic [3:0] c, d, u;
   } evento_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       entrada_serial = 1'b1;
   logic [3:0] centena, dezena, unidade, db_estado;
   logic       medida_pronto, erro_paridade, erro_formato;

   evento_t    fila[$];
   logic [3:0] pend[$];
   logic [3:0] held_c = '0, held_d = '0, held_u = '0;
   int         vectors = 0;
   int         miscompares = 0;
   int         hold_reports = 0;

   receptor_trena_7o1 #(.CLKS_PER_BIT(CPB)) dut (
      .clock          (clock),
      .reset          (reset),
      .entrada_serial (entrada_serial),
      .centena        (centena),
      .dezena         (dezena),
      .unidade        (unidade),
      .medida_pronto  (medida_pronto),
      .erro_paridade  (erro_paridade),
      .erro_formato   (erro_formato),
      .db_estado      (db_estado)
   );

   always #5 clock = ~clock;

   function automatic void push_ev(input int kind, input logic [3:0] c,
                                   input logic [3:0] d, input logic [3:0] u);
      evento_t e;
      e.kind = kind; e.c = c; e.d = d; e.u = u;
      fila.push_back(e);
   endfunction

   // Frame-level rules: up to three digits collected, then '#' publishes them.
   function automatic void model_char(input logic [6:0] ch, input bit ok);
      if (!ok) begin
         push_ev(EV_PAR, '0, '0, '0);
         pend.delete();
      end else if (pend.size() < 3) begin
         if (ch >= 7'h30 && ch <= 7'h39) pend.push_back(4'(ch - 7'h30));
         else begin
            push_ev(EV_FMT, '0, '0, '0);
            pend.delete();
         end
      end else begin
         if (ch == 7'h23) push_ev(EV_PRONTO, pend[0], pend[1], pend[2]);
         else push_ev(EV_FMT, '0, '0, '0);
         pend.delete();
      end
   endfunction

   task automatic bit_time(input logic v);
      entrada_serial = v;
      repeat (CPB) @(negedge clock);
   endtask

   task automatic send_char(input logic [6:0] ch, input bit bad_par, input bit bad_stop);
      logic p;
      p = ~^ch;
      if (bad_par) p = ~p;
      model_char(ch, !(bad_par || bad_stop));
      bit_time(1'b0);
      for (int i = 0; i < 7; i++) bit_time(ch[i]);
      bit_time(p);
      bit_time(!bad_stop);
      if (bad_stop) bit_time(1'b1);
   endtask

   task automatic send_str(input string s);
      byte b;
      for (int i = 0; i < s.len(); i++) begin
         b = s[i];
         send_char(b[6:0], 1'b0, 1'b0);
      end
   endtask

   task automatic check(input string nome, input logic [15:0] act, input logic [15:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, act, req);
      end
   endtask

   task automatic drain(input string nome);
      for (int k = 0; k < 400 && fila.size() != 0; k++) @(negedge clock);
      check(nome, 16'(fila.size()), 16'd0);
   endtask

   // Monitor: pops the scoreboard whenever the DUT pulses, and checks that the
   // digit outputs only move together with medida_pronto.
   initial begin
      evento_t e;
      int      n;
      int      kind;
      forever begin
         @(posedge clock);
         #1;
         n = int'(medida_pronto) + int'(erro_paridade) + int'(erro_formato);
         if (n > 1) check("one_pulse", 16'(n), 16'd1);
         if (n >= 1) begin
            kind = medida_pronto ? EV_PRONTO : (erro_paridade ? EV_PAR : EV_FMT);
            if (fila.size() == 0) begin
               check("unexpected_pulse", 16'(kind), 16'hFFFF);
            end else begin
               e = fila.pop_front();
               check("pulse_kind", 16'(kind), 16'(e.kind));
               if (e.kind == EV_PRONTO && kind == EV_PRONTO) begin
                  check("digits", {4'h0, centena, dezena, unidade}, {4'h0, e.c, e.d, e.u});
                  held_c = e.c; held_d = e.d; held_u = e.u;
               end
            end
         end
         if ({centena, dezena, unidade} !== {held_c, held_d, held_u}) begin
            miscompares++;
            if (hold_reports < 10)
               $display("FAIL digit_hold: got %h%h%h, expected %h%h%h",
                        centena, dezena, unidade, held_c, held_d, held_u);
            hold_reports++;
         end
      end
   end

   initial begin
      logic [6:0] ch;
      int         r;

      repeat (4) @(negedge clock);
      @(posedge clock); #1;
      check("rst_digits", {4'h0, centena, dezena, unidade}, 16'h0000);
      check("rst_pulses", {13'h0, medida_pronto, erro_paridade, erro_formato}, 16'h0);
      check("rst_estado", {12'h0, db_estado}, 16'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2 * CPB) @(negedge clock);

      send_str("123#");
      drain("drain_123");
      bit_time(1'b1);

      send_str("045#");
      send_str("987#");
      drain("drain_b2b");
      bit_time(1'b1);

      send_char(7'h33, 1'b1, 1'b0);
      send_str("123#");
      drain("drain_par");
      bit_time(1'b1);

      send_str("12#");
      send_str("456#");
      drain("drain_fmt2");
      bit_time(1'b1);

      send_str("7891");
      drain("drain_fmt3");
      bit_time(1'b1);

      entrada_serial = 1'b0;
      repeat (2) @(negedge clock);
      entrada_serial = 1'b1;
      repeat (3 * CPB) @(negedge clock);
      check("glitch_estado", {12'h0, db_estado}, 16'h0);

      send_char(7'h35, 1'b0, 1'b1);
      drain("drain_stop");
      bit_time(1'b1);

      // Abort the units character after its second data bit.
      send_str("32");
      ch = 7'h31;
      bit_time(1'b0);
      bit_time(ch[0]);
      bit_time(ch[1]);
      reset = 1'b1;
      entrada_serial = 1'b1;
      pend.delete();
      held_c = '0; held_d = '0; held_u = '0;
      repeat (2) @(negedge clock);
      @(posedge clock); #1;
      check("midrst_digits", {4'h0, centena, dezena, unidade}, 16'h0000);
      check("midrst_estado", {12'h0, db_estado}, 16'h0);
      @(negedge clock);
      reset = 1'b0;
      repeat (2 * CPB) @(negedge clock);
      check("midrst_queue", 16'(fila.size()), 16'd0);
      send_str("321#");
      drain("drain_321");
      bit_time(1'b1);

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7) ch = (pend.size() < 3) ? 7'(7'h30 + $urandom_range(0, 9)) : 7'h23;
         else if (r == 7) ch = 7'($urandom_range(0, 127));
         else ch = (r == 8) ? 7'h23 : 7'($urandom_range(0, 127));
         send_char(ch, r == 9, 1'b0);
         if ($urandom_range(0, 3) == 0) bit_time(1'b1);
      end
      drain("drain_rand");
      repeat (4 * CPB) @(negedge clock);
      check("final_estado", {12'h0, db_estado}, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
